// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding.
// Optional lost-bit tracking is enabled with the SHIFT_LOST_EN macro.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROR = 2'd3
  } shift_op_e;

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered barrel-shifter stage: shifts by STEP when the current amount LSB is set.
// Lost-bit tracking is compiled in with the SHIFT_LOST_EN macro.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
`ifdef SHIFT_LOST_EN
  input  logic             in_lost,
  output logic             out_lost,
`endif
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic [AMT_W-1:0] out_amt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
`ifdef SHIFT_LOST_EN
    logic             lost;
`endif
  } payload_t;

  payload_t                pl_d, pl_q;
  logic                    vld_d, vld_q;
  logic signed [WIDTH-1:0] sdata;
  logic [WIDTH-1:0]        shifted;
  logic                    dropped;

  always_comb begin
    sdata   = $signed(in_data);
    shifted = in_data;
    dropped = 1'b0;
    if (in_amt[0]) begin
      case (shift_op_e'(in_op))
        OP_SLL: begin
          shifted = in_data << STEP;
          dropped = |in_data[WIDTH-1 -: STEP];
        end
        OP_SRL: begin
          shifted = in_data >> STEP;
          dropped = |in_data[STEP-1:0];
        end
        // Sign comes from this stage's input MSB, so chained stages keep it.
        OP_SRA: begin
          shifted = sdata >>> STEP;
          dropped = |in_data[STEP-1:0];
        end
        OP_ROR: begin
          shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
          dropped = 1'b0;
        end
      endcase
    end

    vld_d = vld_q;
    pl_d  = pl_q;
    if (advance) begin
      vld_d     = in_vld;
      pl_d.data = shifted;
      pl_d.op   = in_op;
      pl_d.amt  = in_amt >> 1;
`ifdef SHIFT_LOST_EN
      pl_d.lost = in_lost | dropped;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      pl_q  <= '0;
    end else begin
      vld_q <= vld_d;
      pl_q  <= pl_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = pl_q.data;
  assign out_op   = pl_q.op;
  assign out_amt  = pl_q.amt;
`ifdef SHIFT_LOST_EN
  assign out_lost = pl_q.lost;
`else
  logic unused_dropped;
  assign unused_dropped = dropped;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one stage per shift-amount bit, global stall.
// Define SHIFT_LOST_EN to add the out_lost port reporting discarded 1 bits.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout
`ifdef SHIFT_LOST_EN
  ,
  output logic               out_lost
`endif
);

  // Index 0 is the input beat; index k+1 is the output register of stage k.
  logic               vld_s  [SHAMT_W+1];
  logic [WIDTH-1:0]   data_s [SHAMT_W+1];
  logic [1:0]         op_s   [SHAMT_W+1];
  logic [SHAMT_W-1:0] amt_s  [SHAMT_W+1];
`ifdef SHIFT_LOST_EN
  logic               lost_s [SHAMT_W+1];
`endif
  logic               advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign vld_s[0]  = in_valid;
  assign data_s[0] = din;
  assign op_s[0]   = op;
  assign amt_s[0]  = shift_amt;
`ifdef SHIFT_LOST_EN
  assign lost_s[0] = 1'b0;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k),
      .AMT_W (SHAMT_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .in_vld   (vld_s[k]),
      .in_data  (data_s[k]),
      .in_op    (op_s[k]),
      .in_amt   (amt_s[k]),
`ifdef SHIFT_LOST_EN
      .in_lost  (lost_s[k]),
      .out_lost (lost_s[k+1]),
`endif
      .out_vld  (vld_s[k+1]),
      .out_data (data_s[k+1]),
      .out_op   (op_s[k+1]),
      .out_amt  (amt_s[k+1])
    );
  end

  assign out_valid = vld_s[SHAMT_W];
  assign dout      = data_s[SHAMT_W];
`ifdef SHIFT_LOST_EN
  assign out_lost  = lost_s[SHAMT_W];
`endif

  // The last stage's op and remaining amount have no consumer.
  logic unused_tail;
  assign unused_tail = ^{op_s[SHAMT_W], amt_s[SHAMT_W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=8); lost-bit checks follow SHIFT_LOST_EN.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;
  import barrel_shifter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shift_amt;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
`ifdef SHIFT_LOST_EN
  logic       out_lost;
`endif

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shift_amt (shift_amt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef SHIFT_LOST_EN
    ,
    .out_lost  (out_lost)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [7:0] rot_exp [8] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Drive one beat from a negedge; returns at the negedge after it was accepted.
  task automatic send(input logic [1:0] o, input logic [7:0] d, input logic [2:0] a,
                      input logic [7:0] ed, input logic el, input bit lat, input bit push);
    exp_t e;
    int   n = 0;
    in_valid  = 1'b1;
    op        = o;
    din       = d;
    shift_amt = a;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    e.d = ed; e.l = el; e.cyc = cyc; e.lat = lat;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: compares every transferred result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: dout=0x%0h with empty scoreboard", dout);
        end else begin
          e = exp_q.pop_front();
          chk("dout", int'(dout), int'(e.d));
`ifdef SHIFT_LOST_EN
          chk("out_lost", int'(out_lost), int'(e.l));
`endif
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    shift_amt = '0;
    op        = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_dout", int'(dout), 0);
`ifdef SHIFT_LOST_EN
    chk("reset_out_lost", int'(out_lost), 0);
`endif
    rst = 1'b0;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Directed single operations, issued back to back.
    send(OP_SLL, 8'h96, 3'd3, 8'hB0, 1'b1, 1, 1);
    send(OP_SRA, 8'h96, 3'd2, 8'hE5, 1'b1, 1, 1);
    send(OP_SRL, 8'h96, 3'd7, 8'h01, 1'b1, 1, 1);
    send(OP_SRL, 8'h96, 3'd1, 8'h4B, 1'b0, 1, 1);
    send(OP_ROR, 8'h96, 3'd4, 8'h69, 1'b0, 1, 1);
    send(OP_SLL, 8'h96, 3'd0, 8'h96, 1'b0, 1, 1);
    send(OP_SRL, 8'h96, 3'd0, 8'h96, 1'b0, 1, 1);
    send(OP_SRA, 8'h96, 3'd0, 8'h96, 1'b0, 1, 1);
    send(OP_ROR, 8'h96, 3'd0, 8'h96, 1'b0, 1, 1);
    send(OP_SLL, 8'h01, 3'd7, 8'h80, 1'b0, 1, 1);
    send(OP_SRA, 8'h40, 3'd7, 8'h00, 1'b1, 1, 1);
    send(OP_SRA, 8'hFF, 3'd5, 8'hFF, 1'b1, 1, 1);
    send(OP_SLL, 8'h80, 3'd1, 8'h00, 1'b1, 1, 1);
    drain();
    repeat (2) @(negedge clk);

    // Eight consecutive rotates; each must appear exactly 3 cycles after issue.
    for (int i = 0; i < 8; i++)
      send(OP_ROR, 8'h01, 3'(i), rot_exp[i], 1'b0, 1, 1);
    drain();
    repeat (2) @(negedge clk);

    // Backpressure: fill the pipe, hold out_ready low, then release.
    out_ready = 1'b0;
    send(OP_SLL, 8'h0F, 3'd1, 8'h1E, 1'b0, 0, 1);
    send(OP_SRL, 8'hF0, 3'd4, 8'h0F, 1'b0, 0, 1);
    send(OP_SRA, 8'h80, 3'd3, 8'hF0, 1'b0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_dout", int'(dout), int'(exp_q[0].d));
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);

    // Reset with two beats in flight; nothing may emerge afterwards.
    out_ready = 1'b0;
    send(OP_SLL, 8'h96, 3'd3, 8'hB0, 1'b1, 0, 0);
    send(OP_SRL, 8'h96, 3'd1, 8'h4B, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk("pre_reset_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", int'(out_valid), 0);
    chk("mid_reset_dout", int'(dout), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("no_stale_out_valid", int'(out_valid), 0);
      @(negedge clk);
    end

    // Recovery after reset.
    send(OP_SLL, 8'h96, 3'd3, 8'hB0, 1'b1, 1, 1);
    drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit combinational left/right shifter. It takes WIDTH-bit data, a shift amount and a 2-bit op (logical left, logical right, arithmetic right, rotate right) on a valid/ready input. It decomposes the shift into log2(WIDTH) registered stages, one per shift-amount bit, and returns the result on a valid/ready output. It sits in datapath blocks that need full-width shifts at clock rate without a long combinational path.

Parameters:
- WIDTH, 8, data width. Power of two, minimum 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block accepts the beat this cycle.
- din, input, WIDTH, operand.
- shift_amt, input, SHAMT_W, shift distance 0..WIDTH-1.
- op, input, 2, operation: 0=SLL, 1=SRL, 2=SRA, 3=ROR.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- dout, output, WIDTH, result.
- out_lost, output, 1, bits shifted out. Present only with SHIFT_LOST_EN.

Behaviour:
- Reset (async assert, sync-safe release): all stage valid bits 0, all stage data/op/amt registers 0. Outputs: out_valid=0, dout=0, out_lost=0. in_ready=1 once rst is low.
- Pipeline: SHAMT_W stages. Stage k shifts its operand by 2^k when shift_amt bit k is set, otherwise passes it unchanged. Each stage carries valid, data, op and the remaining amt bits forward. Stage 0 consumes bit 0, the LSB.
- Latency: exactly SHAMT_W cycles from the accept edge to out_valid, with no stall. For WIDTH=8 that is 3 cycles.
- Throughput: one beat per cycle.
- Global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every stage holds, and dout/out_valid stay stable.
  - Bubbles are not collapsed during a stall.
- Input accept when in_valid && in_ready. If in_valid=0 while advancing, a bubble (valid=0) enters.
- Op semantics, per stage:
  - SLL fills with 0 from the LSB.
  - SRL fills with 0 from the MSB.
  - SRA fills with the stage-input MSB, so repeated stages preserve the sign.
  - ROR wraps LSBs into the MSBs.
- shift_amt=0: dout=din for all ops. The result equals a single-step shift by the full amount; no width growth, truncation to WIDTH.
- Reset mid-operation: all in-flight beats are discarded, out_valid drops immediately (async), and nothing is replayed.
- out_valid && !out_ready for many cycles: dout held, no beat lost or duplicated.

Optional Feature:
- Macro SHIFT_LOST_EN.
- Defined:
  - Port out_lost exists. Each stage carries a lost bit, OR-ed with "any 1 bit discarded by this stage".
  - SLL counts bits pushed past the MSB; SRL/SRA count bits pushed past the LSB; ROR never sets it.
  - out_lost is aligned with dout and obeys the same stall and reset rules.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package barrel_shifter_pkg holds:
  - op encoding constants OP_SLL=2'd0, OP_SRL=2'd1, OP_SRA=2'd2, OP_ROR=2'd3, as a typedef'd 2-bit enum;
  - the stage-payload struct: data, op, amt, lost.
- One sub-module is natural: barrel_shift_stage.
  - Parameters: WIDTH, STEP (=2^k).
  - Holds one register stage with enable = advance, async reset.
  - Top generates SHAMT_W instances.

Test Plan (WIDTH=8):
- SLL din=8'h96, amt=3 -> dout=8'hB0 after 3 cycles; out_lost=1 when enabled.
- SRA din=8'h96, amt=2 -> 8'hE5. SRL din=8'h96, amt=7 -> 8'h01 with out_lost=1. SRL 8'h96, amt=1 -> 8'h4B with out_lost=0.
- ROR din=8'h96, amt=4 -> 8'h69 with out_lost=0. amt=0 on all four ops -> 8'h96.
- Back-to-back: 8 beats on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles, in order, first at cycle 3.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, dout unchanged. Release -> results drain in order with no loss or duplicate.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 immediately, dout=0, and no stale results appear after release.
